// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: control-FSM state encodings and the default debounce length.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUNNING = 2'b01,
    ST_PAUSED  = 2'b10,
    ST_ILLEGAL = 2'b11
  } status_e;

  // 10 ms at 50 MHz
  localparam int DB_CYCLES_DEFAULT = 500000;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_START,
    CMD_STOP,
    CMD_RESET
  } cmd_e;

endpackage

// File: rtl/stopwatch_btn_cmd_if.sv
// Button inputs, FSM status feedback and command pulses between the front end and the control FSM.
interface stopwatch_btn_cmd_if;
  // No handshake: every command pulse is a single cycle and is consumed by the FSM in that cycle.
  logic       btn_ss;
  logic       btn_rst;
  logic [1:0] status;
  logic       start;
  logic       stop;
  logic       reset;

  modport master (
    output btn_ss, btn_rst, status,
    input  start, stop, reset
  );

  modport slave (
    input  btn_ss, btn_rst, status,
    output start, stop, reset
  );
endinterface

// File: rtl/btn_debounce.sv
// One pushbutton path: two-flop synchronizer, counting debouncer and rising-edge press detector.
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int  DB_CYCLES = DB_CYCLES_DEFAULT,
  localparam int DB_W      = $clog2(DB_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  logic [1:0]      sync_ff;
  logic            sync;
  logic            level_d;
  logic [DB_W-1:0] cnt;

  assign sync = sync_ff[1];

  // Any cycle where sync agrees with level restarts the count from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_ff <= 2'b00;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
    end else begin
      sync_ff <= {sync_ff[0], btn_raw};
      level_d <= level;
      if (sync == level) begin
        cnt <= '0;
      end else if (cnt == DB_W'(DB_CYCLES - 1)) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + DB_W'(1);
      end
    end
  end

  assign press = level & ~level_d;

endmodule

// File: rtl/stopwatch_btn_cmd.sv
// Command front end: debounces both buttons and turns presses into start/stop/reset pulses.
module stopwatch_btn_cmd
  import stopwatch_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  stopwatch_btn_cmd_if.slave   bus,
  output logic [1:0]           dbg_level
);

  logic level_ss, level_rst;
  logic press_ss, press_rst;
  cmd_e cmd;
  logic start_q, stop_q, reset_q;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_ss (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (bus.btn_ss),
    .level   (level_ss),
    .press   (press_ss)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_rst (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (bus.btn_rst),
    .level   (level_rst),
    .press   (press_rst)
  );

  assign dbg_level = {level_rst, level_ss};

  // Reset wins a same-cycle collision; the start/stop press is dropped, not deferred.
  always_comb begin
    cmd = CMD_NONE;
    if (press_rst) begin
      cmd = CMD_RESET;
    end else if (press_ss) begin
      case (status_e'(bus.status))
        ST_IDLE, ST_PAUSED: cmd = CMD_START;
        ST_RUNNING:         cmd = CMD_STOP;
        default:            cmd = CMD_NONE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      reset_q <= 1'b0;
    end else begin
      start_q <= (cmd == CMD_START);
      stop_q  <= (cmd == CMD_STOP);
      reset_q <= (cmd == CMD_RESET);
    end
  end

  assign bus.start = start_q;
  assign bus.stop  = stop_q;
  assign bus.reset = reset_q;

endmodule

// File: tb/tb_stopwatch_btn_cmd.sv
// Directed bench for stopwatch_btn_cmd with DB_CYCLES=4; output pulses are logged as (type, edge) events.
module tb_stopwatch_btn_cmd;
  import stopwatch_pkg::*;

  localparam int DB = 4;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_level;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  stopwatch_btn_cmd_if bus ();

  stopwatch_btn_cmd #(.DB_CYCLES(DB)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_level (dbg_level)
  );

  // ---------------- scoreboard ----------------
  int          tests = 0;
  int          fails = 0;
  int          onehot_viol = 0;
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];

  function automatic logic [31:0] ev(input logic [1:0] t, input int c);
    logic [31:0] cc;
    cc = c;
    return {t, cc[29:0]};
  endfunction

  always @(negedge clk) begin
    if (bus.start) obs_q.push_back(ev(2'd1, cyc));
    if (bus.stop)  obs_q.push_back(ev(2'd2, cyc));
    if (bus.reset) obs_q.push_back(ev(2'd3, cyc));
    if (int'(bus.start) + int'(bus.stop) + int'(bus.reset) > 1) onehot_viol++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic flush(input string tag);
    int n;
    check({tag, " count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s ev%0d", tag, i), obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Raise buttons at a negedge; returns N, the first edge that samples them.
  task automatic press(input bit ss, input bit rs, output int n);
    n = cyc + 1;
    if (ss) bus.btn_ss  = 1'b1;
    if (rs) bus.btn_rst = 1'b1;
  endtask

  task automatic release_all();
    bus.btn_ss  = 1'b0;
    bus.btn_rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic [4:0]  pat;

    rst         = 1'b1;
    bus.btn_ss  = 1'b0;
    bus.btn_rst = 1'b0;
    bus.status  = ST_IDLE;
    idle(2);
    check("rst start", bus.start, 0);
    check("rst stop",  bus.stop,  0);
    check("rst reset", bus.reset, 0);
    check("rst level", dbg_level, 0);
    rst = 1'b0;

    // Clean press at edge 10 -> start at edge 16
    while (cyc < 9) @(negedge clk);
    press(1, 0, n);
    exp_q.push_back(ev(2'd1, 16));
    idle(20); release_all(); idle(20);
    flush("clean");

    // Toggle: RUNNING -> stop, PAUSED -> start
    bus.status = ST_RUNNING;
    press(1, 0, n);
    exp_q.push_back(ev(2'd2, n + 6));
    idle(20); release_all(); idle(20);
    bus.status = ST_PAUSED;
    press(1, 0, n);
    exp_q.push_back(ev(2'd1, n + 6));
    idle(20); release_all(); idle(20);
    flush("toggle");

    // Bounce 1,0,1,0,1 then held
    bus.status = ST_IDLE;
    pat = 5'b10101;
    for (int i = 0; i < 5; i++) begin
      n = cyc + 1;
      bus.btn_ss = pat[4-i];
      idle(1);
    end
    exp_q.push_back(ev(2'd1, n + 6));
    idle(20); release_all(); idle(20);
    flush("bounce");

    // Isolated 3-cycle glitch
    bus.btn_ss = 1'b1;
    idle(3);
    bus.btn_ss = 1'b0;
    idle(20);
    flush("glitch");

    // Simultaneous press while RUNNING: reset only
    bus.status = ST_RUNNING;
    press(1, 1, n);
    exp_q.push_back(ev(2'd3, n + 6));
    idle(30); release_all(); idle(20);
    flush("simul");

    // Async rst clears a live pulse; held button is a fresh press afterwards
    bus.status = ST_IDLE;
    press(1, 0, n);
    while (cyc < n + 5) @(negedge clk);
    @(posedge clk);
    #2;
    check("pulse live", bus.start, 1);
    rst = 1'b1;
    #1;
    check("async clr start", bus.start, 0);
    idle(3);
    rst = 1'b0;
    n = cyc + 1;
    exp_q.push_back(ev(2'd1, n + 6));
    idle(20); release_all(); idle(20);
    flush("async");

    // rst two cycles into a debounce, btn_rst held through release
    press(0, 1, n);
    idle(3);
    rst = 1'b1;
    #1;
    check("mid start", bus.start, 0);
    check("mid stop",  bus.stop,  0);
    check("mid reset", bus.reset, 0);
    check("mid level", dbg_level, 0);
    idle(3);
    rst = 1'b0;
    n = cyc + 1;
    exp_q.push_back(ev(2'd3, n + 6));
    idle(20); release_all(); idle(20);
    flush("midrst");

    // Illegal status: start/stop ignored, reset honoured
    bus.status = ST_ILLEGAL;
    press(1, 0, n);
    idle(20); release_all(); idle(20);
    press(0, 1, n);
    exp_q.push_back(ev(2'd3, n + 6));
    idle(20); release_all(); idle(20);
    flush("illegal");

    check("onehot", onehot_viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
